// File: rtl/risc_controller.sv
// risc_controller: 8-phase instruction sequencer for the 8-bit RISC CPU.
// Ports: clk, rst (sync, active-high), opcode[2:0], zero in;
//        alu_op[2:0], sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr,
//        data_e, halt, phase[2:0] out.
module risc_controller #(
    parameter bit HALT_STICKY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic [2:0] alu_op,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       wr,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    phase_t     state;
    phase_t     state_next;
    logic       halted;
    logic       halted_next;
    logic [2:0] phase_inc;

    logic is_hlt;
    logic is_skz;
    logic is_sto;
    logic is_jmp;
    logic is_aluop;

    assign is_hlt   = (opcode == OP_HLT);
    assign is_skz   = (opcode == OP_SKZ);
    assign is_sto   = (opcode == OP_STO);
    assign is_jmp   = (opcode == OP_JMP);
    assign is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                      (opcode == OP_XOR) || (opcode == OP_LDA);

    assign alu_op    = opcode;
    assign phase     = state;
    assign phase_inc = state + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= INST_ADDR;
            halted <= 1'b0;
        end else begin
            state  <= state_next;
            halted <= halted_next;
        end
    end

    // A sticky halt freezes the sequencer in OP_ADDR until reset.
    always_comb begin
        state_next  = phase_t'(phase_inc);
        halted_next = halted;
        if (halted) begin
            state_next = OP_ADDR;
        end else if (state == OP_ADDR && is_hlt && HALT_STICKY) begin
            halted_next = 1'b1;
            state_next  = OP_ADDR;
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        if (halted) begin
            halt = 1'b1;
        end else begin
            unique case (state)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = is_hlt;
                end
                OP_FETCH: begin
                    rd = is_aluop;
                end
                ALU_OP: begin
                    rd     = is_aluop;
                    inc_pc = is_skz & zero;
                    ld_pc  = is_jmp;
                    data_e = is_sto;
                end
                STORE: begin
                    rd     = is_aluop;
                    ld_ac  = is_aluop;
                    ld_pc  = is_jmp;
                    inc_pc = is_jmp;
                    wr     = is_sto;
                    data_e = is_sto;
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risc_controller.sv
// tb_risc_controller: directed test of risc_controller phase sequencing.
// Strobe vector order: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}.
module tb_risc_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] opcode = 3'b010;
    logic       zero = 1'b0;

    logic [2:0] alu_op, phase;
    logic sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;

    logic [2:0] ns_alu_op, ns_phase;
    logic ns_sel, ns_rd, ns_ld_ir, ns_inc_pc, ns_ld_pc;
    logic ns_ld_ac, ns_wr, ns_data_e, ns_halt;

    logic [8:0] strobes;
    logic [8:0] ns_strobes;

    int tests = 0;
    int failed = 0;

    assign strobes = {sel, rd, ld_ir, inc_pc, ld_pc,
                      ld_ac, wr, data_e, halt};
    assign ns_strobes = {ns_sel, ns_rd, ns_ld_ir, ns_inc_pc, ns_ld_pc,
                         ns_ld_ac, ns_wr, ns_data_e, ns_halt};

    always #5 clk = ~clk;

    risc_controller #(.HALT_STICKY(1'b1)) u_dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .alu_op(alu_op), .sel(sel), .rd(rd), .ld_ir(ld_ir),
        .inc_pc(inc_pc), .ld_pc(ld_pc), .ld_ac(ld_ac), .wr(wr),
        .data_e(data_e), .halt(halt), .phase(phase)
    );

    risc_controller #(.HALT_STICKY(1'b0)) u_ns (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .alu_op(ns_alu_op), .sel(ns_sel), .rd(ns_rd), .ld_ir(ns_ld_ir),
        .inc_pc(ns_inc_pc), .ld_pc(ns_ld_pc), .ld_ac(ns_ld_ac),
        .wr(ns_wr), .data_e(ns_data_e), .halt(ns_halt),
        .phase(ns_phase)
    );

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        opcode = 3'b010;
        do_reset();
        @(negedge clk);
        tests++;
        if (phase !== 3'd0) begin
            failed++;
            $display("FAIL reset_phase got %0d want 0", phase);
        end
        tests++;
        if (strobes !== 9'b100000000) begin
            failed++;
            $display("FAIL reset_strobes got %b want 100000000", strobes);
        end
        tests++;
        if (alu_op !== 3'b010) begin
            failed++;
            $display("FAIL reset_alu_op got %b want 010", alu_op);
        end
        // run to phase 5, then reset mid-instruction
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (phase !== 3'd5) begin
            failed++;
            $display("FAIL midrun_pre_phase got %0d want 5", phase);
        end
        do_reset();
        @(negedge clk);
        tests++;
        if (phase !== 3'd0) begin
            failed++;
            $display("FAIL midrun_phase got %0d want 0", phase);
        end
        tests++;
        if (strobes !== 9'b100000000) begin
            failed++;
            $display("FAIL midrun_strobes got %b want 100000000", strobes);
        end
    endtask

    task automatic test_add();
        logic [8:0] exp [0:7];
        exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                9'b000100000, 9'b010000000, 9'b010000000, 9'b010001000};
        opcode = 3'b010;
        do_reset();
        for (int p = 0; p < 9; p++) begin
            @(negedge clk);
            tests++;
            if (phase !== 3'(p % 8)) begin
                failed++;
                $display("FAIL add_phase p%0d got %0d want %0d",
                         p, phase, p % 8);
            end
            tests++;
            if (strobes !== exp[p % 8]) begin
                failed++;
                $display("FAIL add_strobes p%0d got %b want %b",
                         p, strobes, exp[p % 8]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_skz();
        logic [8:0] exp [0:7];
        opcode = 3'b001;
        for (int z = 1; z >= 0; z--) begin
            exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                    9'b000100000, 9'b000000000, 9'b000000000, 9'b000000000};
            if (z == 1) exp[6] = 9'b000100000;
            zero = z[0];
            do_reset();
            for (int p = 0; p < 8; p++) begin
                @(negedge clk);
                tests++;
                if (strobes !== exp[p]) begin
                    failed++;
                    $display("FAIL skz_z%0d p%0d got %b want %b",
                             z, p, strobes, exp[p]);
                end
                @(posedge clk);
                #1;
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_sto();
        logic [8:0] exp [0:7];
        exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                9'b000100000, 9'b000000000, 9'b000000010, 9'b000000110};
        opcode = 3'b110;
        zero = 1'b1;
        do_reset();
        for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            tests++;
            if (strobes !== exp[p]) begin
                failed++;
                $display("FAIL sto p%0d got %b want %b", p, strobes, exp[p]);
            end
            @(posedge clk);
            #1;
        end
        zero = 1'b0;
    endtask

    task automatic test_jmp();
        logic [8:0] exp [0:7];
        exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                9'b000100000, 9'b000000000, 9'b000010000, 9'b000110000};
        opcode = 3'b111;
        zero = 1'b1;
        do_reset();
        for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            tests++;
            if (strobes !== exp[p]) begin
                failed++;
                $display("FAIL jmp p%0d got %b want %b", p, strobes, exp[p]);
            end
            @(posedge clk);
            #1;
        end
        zero = 1'b0;
    endtask

    task automatic test_hlt_sticky();
        opcode = 3'b000;
        do_reset();
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        tests++;
        if (phase !== 3'd4 || strobes !== 9'b000100001) begin
            failed++;
            $display("FAIL hlt_p4 got ph%0d %b want ph4 000100001",
                     phase, strobes);
        end
        for (int c = 0; c < 22; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            tests++;
            if (phase !== 3'd4 || strobes !== 9'b000000001) begin
                failed++;
                $display("FAIL hlt_hold c%0d got ph%0d %b want ph4 000000001",
                         c, phase, strobes);
            end
        end
        tests++;
        if (alu_op !== 3'b000) begin
            failed++;
            $display("FAIL hlt_alu_op got %b want 000", alu_op);
        end
        do_reset();
        @(negedge clk);
        tests++;
        if (phase !== 3'd0 || strobes !== 9'b100000000) begin
            failed++;
            $display("FAIL hlt_reset got ph%0d %b want ph0 100000000",
                     phase, strobes);
        end
        // reset asserted on the edge leaving phase 4 beats the halt
        repeat (4) @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        tests++;
        if (phase !== 3'd0 || halt !== 1'b0) begin
            failed++;
            $display("FAIL hlt_rst_dom got ph%0d halt%b want ph0 halt0",
                     phase, halt);
        end
        @(posedge clk);
        #1;
        tests++;
        if (phase !== 3'd1) begin
            failed++;
            $display("FAIL hlt_rst_dom_next got %0d want 1", phase);
        end
    endtask

    task automatic test_hlt_pulse();
        logic [8:0] exp [0:7];
        exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                9'b000100001, 9'b000000000, 9'b000000000, 9'b000000000};
        opcode = 3'b000;
        do_reset();
        for (int p = 0; p < 9; p++) begin
            @(negedge clk);
            tests++;
            if (ns_phase !== 3'(p % 8) || ns_strobes !== exp[p % 8]) begin
                failed++;
                $display("FAIL hlt_pulse p%0d got ph%0d %b want ph%0d %b",
                         p, ns_phase, ns_strobes, p % 8, exp[p % 8]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_skz();
        test_sto();
        test_jmp();
        test_hlt_sticky();
        test_hlt_pulse();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/risc_controller.md
Name: risc_controller

Overview:
- Instruction sequencer for the 8-bit RISC CPU.
- Drives the control strobes for the program counter, instruction register, memory, accumulator and ALU. It consumes the ALU's zero/skip flag, making it the issuing end of the ALU's alu_op/SKZ_cmp interface.
- Each instruction runs as a fixed 8-phase sequence. The block decodes the registered opcode and asserts the matching datapath controls in each phase.

Parameters:
- HALT_STICKY, 1, 1 = once HLT is decoded the sequencer freezes until reset; 0 = halt is a one-phase pulse and sequencing continues.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- opcode  input  3  instruction register opcode field (IR[7:5])
- zero  input  1  ALU SKZ_cmp flag (accumulator == 0 when alu_op is 000/001/110/111)
- alu_op  output  3  opcode forwarded to ALU; equals opcode input
- sel  output  1  address mux select: 1 = PC, 0 = IR operand
- rd  output  1  memory read enable
- ld_ir  output  1  instruction register load
- inc_pc  output  1  PC increment
- ld_pc  output  1  PC load (jump)
- ld_ac  output  1  accumulator load from ALU
- wr  output  1  memory write strobe
- data_e  output  1  accumulator drives data bus
- halt  output  1  halt indication
- phase  output  3  current phase, for debug/trace

Behaviour:
- Opcodes: HLT 000, SKZ 001, ADD 010, AND 011, XOR 100, LDA 101, STO 110, JMP 111.
- ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Phase register is 3 bits: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
- Phase advances by 1 every clock and wraps 7 -> 0, except when halted.
- Separate 1-bit halted flag:
  - Set on the clock edge leaving phase 4 when opcode == HLT and HALT_STICKY = 1.
  - While set, phase holds at 4 and all strobes are 0 except halt = 1.
- Outputs are combinational functions of phase, registered halted flag, opcode and zero (Moore on phase, opcode-qualified). Each phase lasts exactly one clock, so latency from INST_ADDR to ld_ac/wr is 7 clocks.
- Asserted strobes per phase (all unlisted strobes are 0):
  - 0: sel.
  - 1: sel, rd.
  - 2: sel, rd, ld_ir.
  - 3: sel, rd, ld_ir.
  - 4: inc_pc; halt = (opcode == HLT).
  - 5: rd = ALUOP.
  - 6: rd = ALUOP; inc_pc = (opcode == SKZ) & zero; ld_pc = (opcode == JMP); data_e = (opcode == STO).
  - 7: rd = ALUOP; ld_ac = ALUOP; ld_pc = (opcode == JMP); inc_pc = (opcode == JMP); wr = (opcode == STO); data_e = (opcode == STO).
- zero is sampled only in phase 6; it is a don't-care in all other phases.
- alu_op = opcode at all times, including during reset and halt.
- Reset (rst = 1 at a clock edge) sets phase = 0 and clears the halted flag, regardless of the current phase or halt state, including mid-instruction.
- Outputs after reset: sel = 1, halt = 0, phase = 0, all other strobes 0.
- Reset dominates the halt condition in the same cycle.
- opcode is assumed stable from phase 3 onward; a change in phases 0–2 has no effect on strobes other than halt/inc_pc/ld_pc/etc. in phases 4–7.
- Undefined combinations are impossible by construction: ld_pc and wr are never both 1, and ld_ac and wr are never both 1.

Test Plan:
1. Reset mid-run: assert rst in phase 5 with opcode = ADD -> next cycle phase = 0, sel = 1, rd = 0, ld_ac = 0, halt = 0.
2. ADD sequence: opcode = 010 for 8 clocks after reset -> rd = 1 in phases 1, 2, 3, 5, 6, 7; ld_ir = 1 in phases 2, 3; inc_pc = 1 only in phase 4; ld_ac = 1 only in phase 7; wr = 0 throughout; phase wraps 7 -> 0.
3. SKZ with zero = 1 vs zero = 0: opcode = 001 -> inc_pc = 1 in phases 4 and 6 when zero = 1; only in phase 4 when zero = 0; ld_ac = 0 in both cases.
4. STO: opcode = 110 -> data_e = 1 in phases 6 and 7; wr = 1 only in phase 7; rd = 0 in phases 5–7; ld_ac = 0.
5. JMP: opcode = 111 -> ld_pc = 1 in phases 6 and 7; inc_pc = 1 in phases 4 and 7; wr = 0.
6. HLT with HALT_STICKY = 1: opcode = 000 -> halt = 1 in phase 4, and phase stays 4 with halt = 1 for 20+ clocks with all strobes 0. Asserting rst then gives phase = 0 and halt = 0. With HALT_STICKY = 0, halt pulses for one cycle and phase proceeds to 5.
